// File: rtl/rs232c_pkg.sv
// Shared definitions for the RS-232C transmit arbiter.
//   WORD_W      : width of one transmitted word
//   arb_state_e : arbiter lock state (IDLE / LOCKED)
//   cnt_w()     : bits needed to hold a counter value 0..max_val
package rs232c_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rs232c_rr_pick.sv
// Combinational round-robin picker.
//   req_i       : candidate request vector
//   start_i     : index searched first; search wraps upward modulo N
//   grant_o     : one-hot winner (zero when nothing requested)
//   grant_idx_o : binary index of the winner
//   valid_o     : at least one request present
module rs232c_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             valid_o
);

  always_comb begin
    int idx;
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start_i) + k) % N;
      if (!valid_o && req_i[idx]) begin
        valid_o     = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rs232c_tx_arbiter.sv
// Round-robin arbiter sharing one rs232c_buffer write port among N_REQ
// word producers, with packet locking, push pacing and lock timeout.
//
// Handshake: requester i raises req[i] with req_data[i]/req_last[i] stable
// and holds them until it sees the one-cycle ack[i] pulse; the word is
// taken in that same cycle (push/push_data). After ack the requester may
// drop req[i] or present its next word on the following edge.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-requester word pending
//   req_last    : word ends its packet (releases the lock)
//   req_data    : packed words, word i at [32i+31:32i]
//   ack         : one-hot word-taken pulse
//   buf_full    : buffer cannot accept a word this cycle
//   push        : single-cycle write strobe to the buffer
//   push_data   : word written, zero when push is low
//   lock_abort  : one-cycle pulse when a lock owner goes silent too long
module rs232c_tx_arbiter
  import rs232c_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int GAP          = 1,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [WORD_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  input  logic                    buf_full,
  output logic                    push,
  output logic [WORD_W-1:0]       push_data,
  output logic                    lock_abort
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int GAP_W = cnt_w(GAP);
  localparam int TMO_W = cnt_w(LOCK_TIMEOUT);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              push_q, push_d;
  logic [WORD_W-1:0] push_data_q, push_data_d;
  logic              lock_abort_q, lock_abort_d;

  logic [N_REQ-1:0]  elig;
  logic [IDX_W-1:0]  start_idx;
  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              grant;

  // While locked only the owner competes, so the picker returns it or nothing.
  always_comb begin
    elig = req;
    if (state_q == LOCKED) begin
      elig = req & (N_REQ'(1) << owner_q);
    end
    start_idx = (last_grant_q == IDX_W'(N_REQ - 1)) ? '0 : last_grant_q + 1'b1;
  end

  rs232c_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i       (elig),
    .start_i     (start_idx),
    .grant_o     (pick_onehot),
    .grant_idx_o (pick_idx),
    .valid_o     (pick_valid)
  );

  assign grant = !buf_full && (gap_q == '0) && pick_valid;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    gap_d        = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    tmo_d        = tmo_q;
    ack_d        = '0;
    push_d       = 1'b0;
    push_data_d  = '0;
    lock_abort_d = 1'b0;

    if (grant) begin
      ack_d        = pick_onehot;
      push_d       = 1'b1;
      push_data_d  = req_data[int'(pick_idx)*WORD_W +: WORD_W];
      last_grant_d = pick_idx;
      gap_d        = GAP_W'(GAP);
      tmo_d        = '0;
      if (req_last[pick_idx]) begin
        state_d = IDLE;
      end else begin
        state_d = LOCKED;
        owner_d = pick_idx;
      end
    end else if (state_q == LOCKED) begin
      // Only owner silence counts; a stalled but requesting owner keeps the lock.
      if (req[owner_q]) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
        state_d      = IDLE;
        tmo_d        = '0;
        lock_abort_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      gap_q        <= '0;
      tmo_q        <= '0;
      ack_q        <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      lock_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      gap_q        <= gap_d;
      tmo_q        <= tmo_d;
      ack_q        <= ack_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      lock_abort_q <= lock_abort_d;
    end
  end

  assign ack        = ack_q;
  assign push       = push_q;
  assign push_data  = push_data_q;
  assign lock_abort = lock_abort_q;

endmodule

// File: tb/tb_rs232c_tx_arbiter.sv
// Self-checking bench for rs232c_tx_arbiter (N_REQ=2, GAP=1, LOCK_TIMEOUT=8).
// Directed scenario tasks plus a randomized run checked against a
// behavioural model and a push-order scoreboard.
module tb_rs232c_tx_arbiter;

  localparam int N_REQ = 2;
  localparam int GAP   = 1;
  localparam int LT    = 8;
  localparam int W     = 32;

  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_last;
  logic [W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic               buf_full;
  logic               push;
  logic [W-1:0]       push_data;
  logic               lock_abort;

  int n_tests = 0;
  int n_fail  = 0;

  rs232c_tx_arbiter #(
    .N_REQ        (N_REQ),
    .GAP          (GAP),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_last   (req_last),
    .req_data   (req_data),
    .ack        (ack),
    .buf_full   (buf_full),
    .push       (push),
    .push_data  (push_data),
    .lock_abort (lock_abort)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  // ---------------- behavioural reference model ----------------
  // owner = -1 means no lock; idle = cycles the owner has gone without req.
  int               m_owner;
  int               m_last;
  int               m_gap;
  int               m_idle;
  logic             exp_push;
  logic [N_REQ-1:0] exp_ack;
  logic [W-1:0]     exp_data;
  logic             exp_abort;
  logic [W-1:0]     exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner   <= -1;
      m_last    <= N_REQ - 1;
      m_gap     <= 0;
      m_idle    <= 0;
      exp_push  <= 1'b0;
      exp_ack   <= '0;
      exp_data  <= '0;
      exp_abort <= 1'b0;
      exp_q.delete();
    end else begin
      automatic int g = -1;
      if (!buf_full && m_gap == 0) begin
        if (m_owner >= 0) begin
          if (req[m_owner]) g = m_owner;
        end else begin
          for (int k = 1; k <= N_REQ; k++) begin
            automatic int j = (m_last + k) % N_REQ;
            if (g < 0 && req[j]) g = j;
          end
        end
      end
      exp_abort <= 1'b0;
      if (g >= 0) begin
        exp_push <= 1'b1;
        exp_ack  <= N_REQ'(1) << g;
        exp_data <= req_data[g*W +: W];
        exp_q.push_back(req_data[g*W +: W]);
        m_last   <= g;
        m_gap    <= GAP;
        m_idle   <= 0;
        m_owner  <= req_last[g] ? -1 : g;
      end else begin
        exp_push <= 1'b0;
        exp_ack  <= '0;
        exp_data <= '0;
        m_gap    <= (m_gap > 0) ? m_gap - 1 : 0;
        if (m_owner >= 0) begin
          if (req[m_owner]) begin
            m_idle <= 0;
          end else if (m_idle + 1 >= LT) begin
            m_owner   <= -1;
            m_idle    <= 0;
            exp_abort <= 1'b1;
          end else begin
            m_idle <= m_idle + 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_last = '0;
    req_data = '0;
    buf_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n    = 1'b0;
    req      = 2'b11;
    req_last = 2'b11;
    req_data = {32'hbbbb0001, 32'haaaa0000};
    buf_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if ({push, ack, push_data, lock_abort} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: push=%b ack=%b data=%h abort=%b, required all zero",
                 push, ack, push_data, lock_abort);
      end
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (push !== 1'b1 || ack !== 2'b01 || push_data !== 32'haaaa0000) begin
      n_fail++;
      $display("FAIL reset_first_grant: push=%b ack=%b data=%h, required push=1 ack=01 data=aaaa0000",
               push, ack, push_data);
    end
    req = '0;
  endtask

  task automatic test_single_word();
    apply_reset();
    req[0] = 1'b1; req_last[0] = 1'b1; req_data[31:0] = 32'h12345678;
    tick();
    n_tests++;
    if (push !== 1'b1 || ack !== 2'b01 || push_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL single_push: push=%b ack=%b data=%h, required push=1 ack=01 data=12345678",
               push, ack, push_data);
    end
    tick();
    n_tests++;
    if (push !== 1'b0 || ack !== 2'b00) begin
      n_fail++;
      $display("FAIL single_gap: push=%b ack=%b, required push=0 ack=00", push, ack);
    end
    req[0] = 1'b0;
    tick();
    n_tests++;
    if (push !== 1'b0 || ack !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: push=%b ack=%b, required push=0 ack=00", push, ack);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    req = 2'b11; req_last = 2'b11;
    req_data = {32'hff00ff00, 32'h11112222};
    for (int e = 0; e < 8; e++) begin
      logic             ep;
      logic [N_REQ-1:0] ea;
      logic [W-1:0]     ed;
      tick();
      ep = (e % 2 == 0);
      ea = !ep ? 2'b00 : (((e / 2) % 2 == 0) ? 2'b01 : 2'b10);
      ed = !ep ? 32'h0 : (((e / 2) % 2 == 0) ? 32'h11112222 : 32'hff00ff00);
      n_tests++;
      if (push !== ep || ack !== ea || push_data !== ed) begin
        n_fail++;
        $display("FAIL contention_edge%0d: push=%b ack=%b data=%h, required push=%b ack=%b data=%h",
                 e, push, ack, push_data, ep, ea, ed);
      end
    end
    req = '0;
  endtask

  task automatic test_packet_lock();
    apply_reset();
    req = 2'b11; req_last = 2'b10;
    req_data = {32'h5a5a0001, 32'h7800ad16};
    tick();
    n_tests++;
    if (push !== 1'b1 || ack !== 2'b01 || push_data !== 32'h7800ad16) begin
      n_fail++;
      $display("FAIL lock_word0: push=%b ack=%b data=%h, required push=1 ack=01 data=7800ad16",
               push, ack, push_data);
    end
    req_data[31:0] = 32'heee80a0e; req_last[0] = 1'b1;
    tick();
    n_tests++;
    if (push !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_gap: push=%b, required 0", push);
    end
    tick();
    n_tests++;
    if (push !== 1'b1 || ack !== 2'b01 || push_data !== 32'heee80a0e) begin
      n_fail++;
      $display("FAIL lock_word1: push=%b ack=%b data=%h, required push=1 ack=01 data=eee80a0e",
               push, ack, push_data);
    end
    req[0] = 1'b0;
    tick();
    tick();
    n_tests++;
    if (push !== 1'b1 || ack !== 2'b10 || push_data !== 32'h5a5a0001) begin
      n_fail++;
      $display("FAIL lock_release_req1: push=%b ack=%b data=%h, required push=1 ack=10 data=5a5a0001",
               push, ack, push_data);
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    apply_reset();
    d = $urandom;
    buf_full = 1'b1;
    req[1] = 1'b1; req_last[1] = 1'b1; req_data[63:32] = d;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if (push !== 1'b0 || ack !== 2'b00) begin
        n_fail++;
        $display("FAIL backpressure_stall%0d: push=%b ack=%b, required push=0 ack=00", c, push, ack);
      end
    end
    buf_full = 1'b0;
    tick();
    n_tests++;
    if (push !== 1'b1 || ack !== 2'b10 || push_data !== d) begin
      n_fail++;
      $display("FAIL backpressure_release: push=%b ack=%b data=%h, required push=1 ack=10 data=%h",
               push, ack, push_data, d);
    end
    req = '0;
  endtask

  task automatic test_lock_timeout();
    apply_reset();
    req = 2'b11; req_last = 2'b10;
    req_data = {32'h4ba73e0d, 32'h68971e60};
    tick();
    n_tests++;
    if (push !== 1'b1 || ack !== 2'b01 || push_data !== 32'h68971e60) begin
      n_fail++;
      $display("FAIL timeout_word: push=%b ack=%b data=%h, required push=1 ack=01 data=68971e60",
               push, ack, push_data);
    end
    req[0] = 1'b0;
    for (int c = 1; c <= LT; c++) begin
      tick();
      n_tests++;
      if (push !== 1'b0 || lock_abort !== (c == LT)) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: push=%b abort=%b, required push=0 abort=%b",
                 c, push, lock_abort, (c == LT));
      end
    end
    tick();
    n_tests++;
    if (push !== 1'b1 || ack !== 2'b10 || push_data !== 32'h4ba73e0d || lock_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_next: push=%b ack=%b data=%h abort=%b, required push=1 ack=10 data=4ba73e0d abort=0",
               push, ack, push_data, lock_abort);
    end
    req = '0;
  endtask

  task automatic test_reset_mid_lock();
    apply_reset();
    req[0] = 1'b1; req_last[0] = 1'b0; req_data[31:0] = 32'hc0ffee00;
    tick();
    n_tests++;
    if (push !== 1'b1 || ack !== 2'b01) begin
      n_fail++;
      $display("FAIL midlock_grant: push=%b ack=%b, required push=1 ack=01", push, ack);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({push, ack, push_data, lock_abort} !== '0) begin
      n_fail++;
      $display("FAIL midlock_async_clear: push=%b ack=%b data=%h abort=%b, required all zero",
               push, ack, push_data, lock_abort);
    end
    req = 2'b10; req_last = 2'b10; req_data[63:32] = 32'h600dbeef;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (push !== 1'b1 || ack !== 2'b10 || push_data !== 32'h600dbeef) begin
      n_fail++;
      $display("FAIL midlock_after_reset: push=%b ack=%b data=%h, required push=1 ack=10 data=600dbeef",
               push, ack, push_data);
    end
    req = '0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      tick();
      n_tests++;
      if ({push, ack, push_data, lock_abort} !== {exp_push, exp_ack, exp_data, exp_abort}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: push=%b ack=%b data=%h abort=%b, required push=%b ack=%b data=%h abort=%b",
                 c, push, ack, push_data, lock_abort, exp_push, exp_ack, exp_data, exp_abort);
      end
      if (push === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL random_scoreboard%0d: got push data=%h, required no push", c, push_data);
        end else begin
          automatic logic [W-1:0] w = exp_q.pop_front();
          if (push_data !== w) begin
            n_fail++;
            $display("FAIL random_order%0d: data=%h, required %h", c, push_data, w);
          end
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (ack[i] === 1'b1 || (!req[i] && $urandom_range(0, 99) < 15)) begin
          if (ack[i] === 1'b1 && $urandom_range(0, 1) == 0) begin
            req[i] = 1'b0;
          end else begin
            req[i]          = 1'b1;
            req_last[i]     = ($urandom_range(0, 1) == 1);
            req_data[i*W +: W] = $urandom;
          end
        end
      end
      buf_full = ($urandom_range(0, 3) == 0);
    end
    req = '0;
    buf_full = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_last = '0;
    req_data = '0;
    buf_full = 1'b0;
    test_reset();
    test_single_word();
    test_contention();
    test_packet_lock();
    test_backpressure();
    test_lock_timeout();
    test_reset_mid_lock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs232c_tx_arbiter.md
# rs232c_tx_arbiter

Shares one `rs232c_buffer` transmit path among N_REQ word producers, e.g. CPU debug output and trace dump. It accepts 32-bit words over a per-requester req/ack handshake and grants round-robin. It can hold a lock so a multi-word packet goes out contiguously, and it drives the buffer's single-cycle `push`/`push_data` input. Pushes are paced by a minimum gap and gated by the buffer's full flag.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `GAP`, 1: idle cycles forced after every push (≥1).
- `LOCK_TIMEOUT`, 16: idle cycles a locked requester may go without `req` before the lock is aborted (≥2).
- `clk` in 1: system clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req` in N_REQ: requester i has a word pending; held until acked.
- `req_last` in N_REQ: word on `req_data[i]` ends its packet; meaningful only with `req[i]`.
- `req_data` in 32*N_REQ: word i at bits [32i+31:32i]; stable while `req[i]` is high.
- `ack` out N_REQ: one-cycle pulse; word i taken.
- `buf_full` in 1: buffer cannot accept a word this cycle.
- `push` out 1: one-cycle write strobe to `rs232c_buffer`.
- `push_data` out 32: word written; valid only while `push` is high.
- `lock_abort` out 1: one-cycle pulse when a lock times out.

## Operation
- States:
  - IDLE: no lock.
  - LOCKED(owner): only the owner is eligible.
- Eligibility at an edge: `buf_full`=0, gap counter=0, and at least one eligible `req`.
- Grant in IDLE: round-robin. The search starts at `last_grant+1` mod N_REQ. `last_grant` resets to N_REQ-1, so requester 0 wins first.
- On grant to i:
  - `push`=1, `push_data`=`req_data[i]`, `ack[i]`=1, all registered.
  - `last_grant`←i; gap counter←GAP.
- If the granted word has `req_last[i]`=0: enter LOCKED(i). If already LOCKED(i), stay.
- If the granted word has `req_last[i]`=1: go to IDLE.
- In LOCKED, other requests wait regardless of priority.
- Lock timeout counter:
  - Counts cycles in LOCKED with `req[owner]`=0; cleared by any owner request.
  - At LOCK_TIMEOUT: go to IDLE and pulse `lock_abort`.
  - No push happens in the abort cycle.
- Gap counter decrements to 0 each cycle and blocks grants while nonzero. This stops a still-high `req` from being re-granted in the cycle after its ack.
- `buf_full`=1 only stalls. State, lock and timeout counting are unchanged, and the timeout does not run while the owner is requesting.
- `ack` is one-hot or zero. `push`=OR of `ack`.

## Timing
- Reset values: `push`=0, `push_data`=0, `ack`=0, `lock_abort`=0. State IDLE, gap=0, timeout=0, `last_grant`=N_REQ-1.
- Latency: eligible request sampled at edge k → `push`/`ack` high for the cycle after k, visible at edge k+1.
- Requester may drop `req` or present the next word at edge k+1. The earliest next grant is edge k+1+GAP.
- Throughput: one word per GAP+1 cycles maximum.
- `buf_full` is sampled at the grant edge only; a word already pushed is never retracted.
- Reset mid-packet: lock dropped; the requester restarts its packet after reset.
- Simultaneous events:
  - Owner `req` reappearing at the timeout edge is granted and no abort occurs.
  - A new request at the same edge as a lock release waits for the next edge.

## Structure
- Package `rs232c_pkg`: `WORD_W`=32, state enum {IDLE, LOCKED}, counter width helper.
- Sub-module `rs232c_rr_pick`: combinational round-robin picker (req vector, start index → one-hot grant, valid).
- The top instantiates the picker, FSM, gap counter, timeout counter and output registers. Instantiated beside `rs232c_buffer` (divider 16'd5 in bench).

## Test plan
Parameters for all scenarios: N_REQ=2, GAP=1, LOCK_TIMEOUT=8.
- Single word: req0=1, data 32'h12345678, last=1, edge 0 → push/ack0 high for cycle 1 only with push_data 32'h12345678; no second push while req0 stays high through edge 1.
- Contention: req0 and req1 both high (last=1) → grants 0, 1, 0, 1 on edges 0, 2, 4, 6; data 32'h11112222 / 32'hff00ff00 alternate.
- Packet lock: req0 sends 32'h7800ad16 (last=0), 32'heee80a0e (last=1) with req1 held high → both req0 words are pushed before any req1 push.
- Backpressure: `buf_full`=1 for 5 cycles with req1 pending → no push; push occurs on the first edge after `buf_full`=0.
- Lock timeout: req0 sends 32'h68971e60 with last=0, then drops → `lock_abort` pulses 8 cycles later; the pending req1 word 32'h4ba73e0d is pushed on the next edge.
- Reset mid-lock: `rst_n` low during LOCKED(0) → all outputs 0 immediately; after release, req1 alone is granted at once.
